input_port_unit: RTL and testbench

Input-side requester of a 3-port mesh router (local, X1, Y1) in the 2x4 mesh NoC. Each instance sits on one router input, one per port. It buffers single-flit packets in a small FIFO and runs XY route computation on the head flit. It drives that route as the request into the switch allocator, watches the allocator's registered grants, and pops and forwards the head flit to the crossbar when its grant arrives.

---
 rtl/noc_pkg.sv | 32 +++
 rtl/flit_fifo.sv | 51 +++++
 rtl/input_port_unit.sv | 94 +++++++++
 tb/tb_input_port_unit.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh NoC port/switch codes and flit field helpers
package noc_pkg;

    localparam logic [2:0] OUT_NONE       = 3'd0;
    localparam logic [2:0] OUT_LOCAL_PORT = 3'd1;
    localparam logic [2:0] OUT_X1_PORT    = 3'd2;
    localparam logic [2:0] OUT_Y1_PORT    = 3'd3;

    localparam logic [2:0] SW_STOP  = 3'd0;
    localparam logic [2:0] SW_LOCAL = 3'd1;
    localparam logic [2:0] SW_X1    = 3'd2;
    localparam logic [2:0] SW_Y1    = 3'd3;

    // Widths are elaboration constants at every call site, so these reduce to plain slices.
    function automatic logic [7:0] dst_x_of(input logic [63:0] flit,
                                            input int unsigned data_w,
                                            input int unsigned x_w);
        logic [63:0] w_mask;
        w_mask = (64'd1 << x_w) - 64'd1;
        return 8'((flit >> (data_w - x_w)) & w_mask);
    endfunction

    function automatic logic [7:0] dst_y_of(input logic [63:0] flit,
                                            input int unsigned data_w,
                                            input int unsigned x_w,
                                            input int unsigned y_w);
        logic [63:0] w_mask;
        w_mask = (64'd1 << y_w) - 64'd1;
        return 8'((flit >> (data_w - x_w - y_w)) & w_mask);
    endfunction

endpackage

// File: rtl/flit_fifo.sv
// rtl/flit_fifo.sv - synchronous single-clock flit FIFO with registered head pointer
module flit_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    // Callers gate push with not-full and pop with not-empty; pointers wrap since DEPTH is 2^n.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                r_count <= r_count + 1'b1;
            end else if (pop && !push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule

// File: rtl/input_port_unit.sv
// rtl/input_port_unit.sv - router input port: flit buffer, XY route request, grant-driven pop
module input_port_unit
    import noc_pkg::*;
#(
    parameter int         DATA_W  = 16,
    parameter int         X_W     = 1,
    parameter int         Y_W     = 2,
    parameter int         DEPTH   = 4,
    parameter int         LOCAL_X = 0,
    parameter int         LOCAL_Y = 0,
    parameter logic [2:0] PORT_ID = SW_LOCAL
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_flit,
    output logic                   in_ready,
    input  logic                   sa_en,
    input  logic [2:0]             out_local_sw,
    input  logic [2:0]             out_x_sw,
    input  logic [2:0]             out_y_sw,
    output logic [2:0]             port_dst,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_flit,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_stale
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              r_sa_en_q;
    logic              r_err_stale;
    logic [DATA_W-1:0] w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_nonempty;
    logic              w_push;
    logic              w_match;
    logic              w_grant;
    logic [X_W-1:0]    w_dst_x;
    logic [Y_W-1:0]    w_dst_y;
    logic [2:0]        w_route;

    assign w_nonempty = (w_count != '0);
    assign in_ready   = (w_count != CNT_W'(DEPTH));
    assign w_push     = in_valid && in_ready;

    // Grant inputs are allocator flops, so feeding grant back into port_dst is loop-free.
    assign w_match = (out_local_sw == PORT_ID) || (out_x_sw == PORT_ID) || (out_y_sw == PORT_ID);
    assign w_grant = r_sa_en_q && w_nonempty && w_match;

    flit_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_grant),
        .wdata (in_flit),
        .head  (w_head),
        .count (w_count)
    );

    assign w_dst_x = X_W'(dst_x_of(64'(w_head), DATA_W, X_W));
    assign w_dst_y = Y_W'(dst_y_of(64'(w_head), DATA_W, X_W, Y_W));

    always_comb begin
        w_route = OUT_LOCAL_PORT;
        if (w_dst_x != X_W'(LOCAL_X)) begin
            w_route = OUT_X1_PORT;
        end else if (w_dst_y != Y_W'(LOCAL_Y)) begin
            w_route = OUT_Y1_PORT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa_en_q   <= 1'b0;
            r_err_stale <= 1'b0;
        end else begin
            r_sa_en_q <= sa_en;
            if (r_sa_en_q && !w_nonempty && w_match) begin
                r_err_stale <= 1'b1;
            end
        end
    end

    // Request is withdrawn in the grant cycle so the allocator never serves one flit twice.
    assign port_dst  = (w_nonempty && !w_grant) ? w_route : OUT_NONE;
    assign out_valid = w_grant;
    assign out_flit  = w_nonempty ? w_head : '0;
    assign count     = w_count;
    assign err_stale = r_err_stale;

endmodule

// File: tb/tb_input_port_unit.sv
// tb/tb_input_port_unit.sv - directed table-driven bench for input_port_unit
module tb_input_port_unit;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_flit;
    logic        in_ready;
    logic        sa_en;
    logic [2:0]  out_local_sw, out_x_sw, out_y_sw;
    logic [2:0]  port_dst;
    logic        out_valid;
    logic [15:0] out_flit;
    logic [2:0]  count;
    logic        err_stale;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;

    always #5 clk = ~clk;

    input_port_unit #(
        .DATA_W (16), .X_W (1), .Y_W (2), .DEPTH (4),
        .LOCAL_X (0), .LOCAL_Y (1), .PORT_ID (SW_LOCAL)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_flit (in_flit), .in_ready (in_ready),
        .sa_en (sa_en),
        .out_local_sw (out_local_sw), .out_x_sw (out_x_sw), .out_y_sw (out_y_sw),
        .port_dst (port_dst), .out_valid (out_valid), .out_flit (out_flit),
        .count (count), .err_stale (err_stale)
    );

    typedef struct {
        logic [15:0] flit;
        logic [2:0]  exp_dst;
        int          grant_line;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_grants();
        out_local_sw = SW_STOP;
        out_x_sw     = SW_STOP;
        out_y_sw     = SW_STOP;
    endtask

    task automatic set_grant(input int line);
        clear_grants();
        case (line)
            0:       out_local_sw = SW_LOCAL;
            1:       out_x_sw     = SW_LOCAL;
            default: out_y_sw     = SW_LOCAL;
        endcase
    endtask

    task automatic push(input logic [15:0] f);
        in_valid = 1'b1;
        in_flit  = f;
        step();
        in_valid = 1'b0;
        model_cnt++;
        chk("push_count", 32'(count), 32'(model_cnt));
    endtask

    task automatic do_pop(input logic [15:0] exp_flit, input int line);
        sa_en = 1'b1;
        step();
        sa_en = 1'b0;
        set_grant(line);
        #1;
        chk("pop_valid", 32'(out_valid), 32'd1);
        chk("pop_flit", 32'(out_flit), 32'(exp_flit));
        chk("pop_dst_dropped", 32'(port_dst), 32'(OUT_NONE));
        step();
        clear_grants();
        #1;
        model_cnt--;
        chk("pop_count", 32'(count), 32'(model_cnt));
        chk("pop_strobe_single", 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[7];
    int   pulses;

    initial begin
        vecs[0] = '{16'h2000, OUT_LOCAL_PORT, 0};
        vecs[1] = '{16'h6000, OUT_Y1_PORT,    1};
        vecs[2] = '{16'h8000, OUT_X1_PORT,    2};
        vecs[3] = '{16'hA000, OUT_X1_PORT,    0};
        vecs[4] = '{16'h0000, OUT_Y1_PORT,    1};
        vecs[5] = '{16'h3FFF, OUT_LOCAL_PORT, 2};
        vecs[6] = '{16'h4000, OUT_Y1_PORT,    0};

        rst = 1'b1; in_valid = 1'b0; in_flit = '0; sa_en = 1'b0;
        clear_grants();
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_port_dst", 32'(port_dst), 32'(OUT_NONE));
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_flit", 32'(out_flit), 32'd0);
        chk("rst_err_stale", 32'(err_stale), 32'd0);

        // Spec latency: push at E0, request visible, sa_en registers at E1, pop at E2
        push(16'h8000);
        chk("first_route", 32'(port_dst), 32'(OUT_X1_PORT));
        chk("no_bypass", 32'(out_valid), 32'd0);
        do_pop(16'h8000, 1);

        for (int i = 0; i < 7; i++) begin
            push(vecs[i].flit);
            chk($sformatf("route_%0d", i), 32'(port_dst), 32'(vecs[i].exp_dst));
            do_pop(vecs[i].flit, vecs[i].grant_line);
            chk($sformatf("idle_dst_%0d", i), 32'(port_dst), 32'(OUT_NONE));
        end

        // Fill to DEPTH, then an extra offered flit must be refused
        for (int i = 0; i < 4; i++) push(16'h2001 + 16'(i));
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_flit = 16'hBEEF;
        step();
        in_valid = 1'b0;
        chk("full_hold_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) do_pop(16'h2001 + 16'(i), i % 3);

        // Push and pop on the same edge leaves count unchanged
        push(16'h2000);
        push(16'h8000);
        sa_en = 1'b1;
        step();
        sa_en = 1'b0;
        set_grant(0);
        in_valid = 1'b1; in_flit = 16'h6000;
        #1;
        chk("pp_valid", 32'(out_valid), 32'd1);
        step();
        in_valid = 1'b0;
        clear_grants();
        #1;
        chk("pp_count", 32'(count), 32'd2);
        chk("pp_head_route", 32'(port_dst), 32'(OUT_X1_PORT));
        model_cnt = 2;

        // One sa_en pulse, grant held three cycles: exactly one pop
        sa_en = 1'b1;
        step();
        sa_en = 1'b0;
        set_grant(2);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (out_valid) pulses++;
            step();
        end
        clear_grants();
        #1;
        chk("stale_pulses", 32'(pulses), 32'd1);
        chk("stale_count", 32'(count), 32'd1);
        chk("stale_err_clean", 32'(err_stale), 32'd0);
        model_cnt = 1;
        do_pop(16'h6000, 1);

        // Grant while empty
        sa_en = 1'b1;
        step();
        sa_en = 1'b0;
        set_grant(0);
        #1;
        chk("empty_no_pop", 32'(out_valid), 32'd0);
        step();
        clear_grants();
        #1;
        chk("empty_err_set", 32'(err_stale), 32'd1);
        chk("empty_count", 32'(count), 32'd0);
        step();
        chk("err_sticky", 32'(err_stale), 32'd1);

        // Reset mid-operation
        push(16'h8000);
        push(16'h6000);
        push(16'hA000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_cnt = 0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_dst", 32'(port_dst), 32'(OUT_NONE));
        chk("mid_rst_err", 32'(err_stale), 32'd0);
        push(16'h2000);
        chk("post_rst_route", 32'(port_dst), 32'(OUT_LOCAL_PORT));
        do_pop(16'h2000, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
